// File: rtl/mem2p_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem2p_port_arbiter
// Purpose  : Round-robin arbiter with bounded hold that shares one 256x16
//            two-port synchronous memory between the lu_processor core
//            (requester 0) and a loader/DMA engine (requester 1). Read data
//            is steered back to the issuing requester one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module mem2p_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata_out,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_G0   = 2'd1;
  localparam logic [1:0] c_S_G1   = 2'd2;

  // Last hold count value; the counter saturates here so that a requester
  // which held the memory uncontended yields right after one more transfer
  // once the other side starts waiting.
  localparam logic [3:0] c_HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [3:0]    r_hold_cnt;
  logic          r_last;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [AW-1:0] r_addr_q;
  logic [DW-1:0] r_wdata_q;

  logic          w_iss0;
  logic          w_iss1;
  logic          w_hold_done;

  // A transfer issues whenever the granted requester is still requesting.
  assign w_iss0      = (r_state == c_S_G0) && req0;
  assign w_iss1      = (r_state == c_S_G1) && req1;
  assign w_hold_done = (r_hold_cnt == c_HOLD_LAST);

  // State register: grant FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: round-robin on ties, bounded hold under contention,
  // direct handoff when the other requester is waiting.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (req0 && req1) begin
          w_next = r_last ? c_S_G0 : c_S_G1;
        end else if (req0) begin
          w_next = c_S_G0;
        end else if (req1) begin
          w_next = c_S_G1;
        end
      end
      c_S_G0: begin
        if (!req0) begin
          w_next = req1 ? c_S_G1 : c_S_IDLE;
        end else if (req1 && w_hold_done) begin
          w_next = c_S_G1;
        end
      end
      c_S_G1: begin
        if (!req1) begin
          w_next = req0 ? c_S_G0 : c_S_IDLE;
        end else if (req0 && w_hold_done) begin
          w_next = c_S_G0;
        end
      end
      default: w_next = c_S_IDLE;
    endcase
  end

  // Hold counter and round-robin pointer: cleared/updated on grant entry,
  // counted per issued transfer while the grant is kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold_cnt <= 4'd0;
      r_last     <= 1'b1;
    end else if (w_next != r_state) begin
      r_hold_cnt <= 4'd0;
      if (w_next == c_S_G0) begin
        r_last <= 1'b0;
      end else if (w_next == c_S_G1) begin
        r_last <= 1'b1;
      end
    end else if ((w_iss0 || w_iss1) && !w_hold_done) begin
      r_hold_cnt <= r_hold_cnt + 4'd1;
    end
  end

  // Read tag and command mirror: remember who owns the in-flight read and
  // the last address/data driven so idle cycles do not toggle the bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
    end else begin
      r_rvalid0 <= w_iss0 && !we0;
      r_rvalid1 <= w_iss1 && !we1;
      if (w_iss0) begin
        r_addr_q  <= addr0;
        r_wdata_q <= wdata0;
      end else if (w_iss1) begin
        r_addr_q  <= addr1;
        r_wdata_q <= wdata1;
      end
    end
  end

  // Output logic: registered grants plus the combinational command mux.
  always_comb begin
    gnt0      = (r_state == c_S_G0);
    gnt1      = (r_state == c_S_G1);
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = r_addr_q;
    mem_wdata = r_wdata_q;
    if (w_iss0) begin
      mem_we    = we0;
      mem_re    = !we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (w_iss1) begin
      mem_we    = we1;
      mem_re    = !we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata_out = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem2p_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem2p_port_arbiter
// Purpose  : Directed bench for mem2p_port_arbiter with a behavioural
//            256x16 synchronous memory and a read-return scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem2p_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata_out;
  logic        mem_we, mem_re;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];

  mem2p_port_arbiter #(.AW(8), .DW(16), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata_out(rdata_out), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (rvalid0) begin
      if (exp0.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
      else chk("rdata0", {16'd0, rdata_out}, {16'd0, exp0.pop_front()});
    end
    if (rvalid1) begin
      if (exp1.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
      else chk("rdata1", {16'd0, rdata_out}, {16'd0, exp1.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] gpat;
    gpat = 10'b0011110000;   // bit i = 1 -> requester 1 granted in cycle i
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[5]    = 16'h1234;
    mem_rdata = 16'h0000;

    // Reset with both requesting (writes so no reads are outstanding).
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 8'h80; addr1 = 8'h90; wdata0 = 16'h0; wdata1 = 16'h0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
    end
    step();
    rst = 1'b1;
    step();

    // Contention: 4 cycles each, direct handoff.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("cont_gnt1_%0d", i), gnt1, gpat[i]);
      chk($sformatf("cont_gnt0_%0d", i), gnt0, !gpat[i]);
      chk($sformatf("cont_we_%0d", i), mem_we, 1);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // Single requester 1: write burst then read burst.
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'hA000;
    step();
    for (int k = 0; k < 4; k++) begin
      addr1 = 8'h10 + 8'(k); wdata1 = 16'hA000 + 16'(k);
      @(negedge clk);
      chk($sformatf("wr_gnt1_%0d", k), gnt1, 1);
      chk($sformatf("wr_we_%0d", k), mem_we, 1);
      chk($sformatf("wr_addr_%0d", k), mem_addr, 8'h10 + 8'(k));
      step();
    end
    for (int k = 0; k < 4; k++) begin
      we1 = 1'b0; addr1 = 8'h10 + 8'(k);
      exp1.push_back(16'hA000 + 16'(k));
      @(negedge clk);
      chk($sformatf("rd_re_%0d", k), mem_re, 1);
      step();
    end
    req1 = 1'b0;
    repeat (3) step();

    // Read straddling handoff: requester 0 reads 0x05 through its hold.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 16'hBEEF;
    step();
    for (int k = 0; k < 4; k++) begin
      exp0.push_back(16'h1234);
      @(negedge clk);
      chk($sformatf("str_gnt0_%0d", k), gnt0, 1);
      chk($sformatf("str_re_%0d", k), mem_re, 1);
      step();
    end
    @(negedge clk);
    chk("str_gnt1", gnt1, 1);
    chk("str_rvalid0", rvalid0, 1);
    chk("str_rdata", rdata_out, 16'h1234);
    chk("str_rvalid1", rvalid1, 0);
    step();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // Early release: req0 drops after 2 transfers, req1 waiting.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h60;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h50;
    step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("er_gnt0_%0d", k), gnt0, 1);
      chk($sformatf("er_we_%0d", k), mem_we, 1);
      step();
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("er_drop_gnt0", gnt0, 1);
    chk("er_drop_we", mem_we, 0);
    step();
    req0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("er_gnt1_%0d", k), gnt1, 1);
      chk($sformatf("er_g1_gnt0_%0d", k), gnt0, 0);
      step();
    end
    @(negedge clk);
    chk("er_back_gnt0", gnt0, 1);
    chk("er_back_gnt1", gnt1, 0);
    step();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // Reset mid-burst: read issues, reset sampled at the next edge.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    step();
    @(negedge clk);
    chk("mr_gnt1", gnt1, 1);
    chk("mr_re", mem_re, 1);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("mr_rvalid1", rvalid1, 0);
    chk("mr_gnt1_rst", gnt1, 0);
    chk("mr_gnt0_rst", gnt0, 0);
    chk("mr_re_rst", mem_re, 0);
    step();
    rst = 1'b1; req1 = 1'b0;
    step();
    @(negedge clk);
    chk("mr_rvalid1_after", rvalid1, 0);
    chk("mr_re_after", mem_re, 0);
    repeat (2) step();

    chk("sb_exp0_empty", exp0.size(), 0);
    chk("sb_exp1_empty", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
